// File: rtl/noc_eject_deserializer_pkg.sv
// noc_eject_deserializer_pkg: shared types and sizing helper for the NoC eject path
package noc_eject_deserializer_pkg;
  typedef struct packed {
    logic overflow;
    logic frag;
  } err_t;
  function automatic int log2c(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/noc_eject_deserializer_if.sv
// noc_eject_deserializer_if: credit-flow flit link and AXI-Stream beat bundles
interface noc_eject_link_if #(parameter int FLIT_WIDTH = 64, parameter int DEST_WIDTH = 6);
  logic [FLIT_WIDTH-1:0] data;
  logic [DEST_WIDTH-1:0] dest;
  logic is_tail;
  logic send;
  logic credit;
  modport master (output data, dest, is_tail, send, input credit);
  modport slave (input data, dest, is_tail, send, output credit);
endinterface

interface noc_eject_axis_if #(parameter int TDATA_WIDTH = 64, parameter int TID_WIDTH = 2,
                              parameter int TDEST_WIDTH = 4);
  logic tvalid;
  logic tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic tlast;
  logic [TID_WIDTH-1:0] tid;
  logic [TDEST_WIDTH-1:0] tdest;
  modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
  modport slave (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/noc_eject_deserializer_fifo.sv
// noc_flit_fifo: synchronous circular flit buffer with occupancy count
module noc_flit_fifo import noc_eject_deserializer_pkg::*; #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = log2c(DEPTH);
  localparam int CW = log2c(DEPTH + 1);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  assign o_full = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_rdata = r_mem[r_rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
      if (i_pop) r_rp <= (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp] <= i_wdata;
endmodule

// File: rtl/noc_eject_deserializer.sv
// noc_eject_deserializer: buffers credit-flow flits and regroups them into AXI-Stream beats
module noc_eject_deserializer import noc_eject_deserializer_pkg::*; #(
  parameter int TDATA_WIDTH = 64,
  parameter int TID_WIDTH = 2,
  parameter int TDEST_WIDTH = 4,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR,
  parameter int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH,
  parameter int BUFFER_DEPTH = 2
) (
  input  logic clk_noc,
  input  logic rst_noc,
  noc_eject_link_if.slave link,
  noc_eject_axis_if.master axis_out,
  output logic err_overflow,
  output logic err_frag
);
  localparam int SF = SERIALIZATION_FACTOR;
  localparam int IW = log2c(SF);
  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic is_tail;
  } flit_t;
  if (TDATA_WIDTH != FLIT_WIDTH * SERIALIZATION_FACTOR) begin : g_bad_width
    $error("TDATA_WIDTH must equal FLIT_WIDTH*SERIALIZATION_FACTOR");
  end
  flit_t w_wflit, w_rflit;
  logic w_full, w_empty, w_push, w_pop, w_last, w_out_free;
  logic [TDATA_WIDTH-1:0] w_beat;
  logic [DEST_WIDTH-1:0] w_dest;
  logic [IW-1:0] r_idx;
  logic [TDATA_WIDTH-1:0] r_asm;
  logic [DEST_WIDTH-1:0] r_dest;
  logic r_credit, r_tvalid, r_tlast;
  logic [TDATA_WIDTH-1:0] r_tdata;
  logic [TID_WIDTH-1:0] r_tid;
  logic [TDEST_WIDTH-1:0] r_tdest;
  err_t r_err;
  assign w_wflit = '{data: link.data, dest: link.dest, is_tail: link.is_tail};
  assign w_last = r_idx == IW'(SF - 1);
  assign w_out_free = !r_tvalid || axis_out.tready;
  assign w_pop = !w_empty && (!w_last || w_out_free);
  // a pop in the same cycle frees the slot, so a push into a full FIFO is still safe
  assign w_push = link.send && (!w_full || w_pop);
  assign w_dest = (r_idx == '0) ? w_rflit.dest : r_dest;
  always_comb begin
    w_beat = r_asm;
    w_beat[(SF-1)*FLIT_WIDTH +: FLIT_WIDTH] = w_rflit.data;
  end
  noc_flit_fifo #(.W($bits(flit_t)), .DEPTH(BUFFER_DEPTH)) u_fifo (
    .clk(clk_noc), .rst(rst_noc), .i_push(w_push), .i_pop(w_pop),
    .i_wdata(w_wflit), .o_rdata(w_rflit), .o_full(w_full), .o_empty(w_empty)
  );
  always_ff @(posedge clk_noc or posedge rst_noc)
    if (rst_noc) begin
      r_idx <= '0;
      r_asm <= '0;
      r_dest <= '0;
      r_credit <= 1'b0;
      r_tvalid <= 1'b0;
      r_tdata <= '0;
      r_tlast <= 1'b0;
      r_tid <= '0;
      r_tdest <= '0;
      r_err <= '0;
    end else begin
      r_credit <= w_pop;
      r_err.overflow <= r_err.overflow | (link.send && w_full && !w_pop);
      r_err.frag <= r_err.frag | (w_pop && !w_last && w_rflit.is_tail);
      if (w_pop) begin
        r_idx <= w_last ? '0 : r_idx + 1'b1;
        if (r_idx == '0) r_dest <= w_rflit.dest;
        if (!w_last) r_asm[r_idx*FLIT_WIDTH +: FLIT_WIDTH] <= w_rflit.data;
      end
      if (w_pop && w_last) begin
        r_tvalid <= 1'b1;
        r_tdata <= w_beat;
        r_tlast <= w_rflit.is_tail;
        r_tid <= w_dest[DEST_WIDTH-1:TDEST_WIDTH];
        r_tdest <= w_dest[TDEST_WIDTH-1:0];
      end else if (axis_out.tready) r_tvalid <= 1'b0;
    end
  assign link.credit = r_credit;
  assign axis_out.tvalid = r_tvalid;
  assign axis_out.tdata = r_tdata;
  assign axis_out.tlast = r_tlast;
  assign axis_out.tid = r_tid;
  assign axis_out.tdest = r_tdest;
  assign err_overflow = r_err.overflow;
  assign err_frag = r_err.frag;
endmodule

// File: tb/tb_noc_eject_deserializer.sv
// tb_noc_eject_deserializer: three instances (SF=1,2,4) checked against a flit-queue beat model
module tb_noc_eject_deserializer;
  typedef struct packed {
    logic [63:0] d;
    logic [5:0] dest;
    logic tail;
  } mflit_t;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  logic [63:0] b_data [3];
  logic [5:0] b_dest [3];
  logic [2:0] b_tail, b_send, b_tready, b_tvalid, b_tlast, b_credit, b_ovf, b_frag;
  logic [63:0] b_tdata [3];
  logic [1:0] b_tid [3];
  logic [3:0] b_tdest [3];
  int vectors = 0, miscompares = 0;
  mflit_t mq [3][$];
  int acc [3] = '{0, 0, 0};
  int cred [3] = '{0, 0, 0};
  int mpos [3] = '{0, 0, 0};
  logic [2:0] exp_ovf = '0, exp_frag = '0;
  logic [2:0] p_hold = '0;
  logic [63:0] p_data [3];
  logic [6:0] p_side [3];

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int SF = 1 << g;
    localparam int FW = 64 / SF;
    noc_eject_link_if #(.FLIT_WIDTH(FW), .DEST_WIDTH(6)) lnk ();
    noc_eject_axis_if #(.TDATA_WIDTH(64), .TID_WIDTH(2), .TDEST_WIDTH(4)) ax ();
    assign lnk.data = b_data[g][FW-1:0];
    assign lnk.dest = b_dest[g];
    assign lnk.is_tail = b_tail[g];
    assign lnk.send = b_send[g];
    assign ax.tready = b_tready[g];
    assign b_credit[g] = lnk.credit;
    assign b_tvalid[g] = ax.tvalid;
    assign b_tdata[g] = ax.tdata;
    assign b_tlast[g] = ax.tlast;
    assign b_tid[g] = ax.tid;
    assign b_tdest[g] = ax.tdest;
    noc_eject_deserializer #(.SERIALIZATION_FACTOR(SF), .BUFFER_DEPTH(2)) dut (
      .clk_noc(clk), .rst_noc(rst), .link(lnk.slave), .axis_out(ax.master),
      .err_overflow(b_ovf[g]), .err_frag(b_frag[g])
    );
  end

  function automatic void chk(string name, int i, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[inst %0d]: got %h expected %h", name, i, act, exp);
    end
  endfunction

  function automatic logic [63:0] fmask(int i);
    return ~64'd0 >> (64 - (64 >> i));
  endfunction

  // Model: a beat accepted on instance i consumes the next 2**i accepted flits in order
  always @(negedge clk) begin : cmp
    logic [63:0] ed;
    logic [6:0] es;
    mflit_t f;
    if (rst) p_hold = '0;
    else for (int i = 0; i < 3; i++) begin
      if (b_credit[i]) begin
        cred[i]++;
        chk("credit_bound", i, 64'(cred[i] <= acc[i]), 64'd1);
      end
      if (p_hold[i]) begin
        chk("hold_valid", i, b_tvalid[i], 1);
        chk("hold_data", i, b_tdata[i], p_data[i]);
        chk("hold_side", i, {b_tlast[i], b_tid[i], b_tdest[i]}, p_side[i]);
      end
      if (b_tvalid[i] && b_tready[i]) begin
        if (mq[i].size() < (1 << i)) chk("beat_without_flits", i, mq[i].size(), 1 << i);
        else begin
          ed = '0;
          es = '0;
          for (int k = 0; k < (1 << i); k++) begin
            f = mq[i].pop_front();
            ed |= f.d << (k * (64 >> i));
            if (k == 0) es[5:0] = f.dest;
            es[6] = f.tail;
          end
          chk("beat_data", i, b_tdata[i], ed);
          chk("beat_side", i, {b_tlast[i], b_tid[i], b_tdest[i]}, es);
        end
      end
      p_hold[i] = b_tvalid[i] && !b_tready[i];
      p_data[i] = b_tdata[i];
      p_side[i] = {b_tlast[i], b_tid[i], b_tdest[i]};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int i, logic [63:0] d, logic [5:0] dst, logic tl, bit ok);
    b_data[i] = d;
    b_dest[i] = dst;
    b_tail[i] = tl;
    b_send[i] = 1'b1;
    if (ok) begin
      mq[i].push_back('{d & fmask(i), dst, tl});
      acc[i]++;
      if (tl && mpos[i] != (1 << i) - 1) exp_frag[i] = 1'b1;
      mpos[i] = (mpos[i] + 1) % (1 << i);
    end else exp_ovf[i] = 1'b1;
    tick();
    b_send[i] = 1'b0;
  endtask

  task automatic wait_valid(int i, int budget);
    int n = 0;
    @(negedge clk);
    while (!b_tvalid[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("tvalid_timeout", i, b_tvalid[i], 1);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mpos[i] = 0;
    end
    exp_ovf = '0;
    exp_frag = '0;
  endtask

  task automatic single_flit(string tag);
    drive(0, 64'hA5, 6'h2B, 1'b1, 1'b1);
    @(negedge clk);
    chk({tag, "_early_valid"}, 0, b_tvalid[0], 0);
    tick();
    @(negedge clk);
    chk({tag, "_valid"}, 0, b_tvalid[0], 1);
    chk({tag, "_tdata"}, 0, b_tdata[0], 64'hA5);
    chk({tag, "_tid"}, 0, b_tid[0], 2'h2);
    chk({tag, "_tdest"}, 0, b_tdest[0], 4'hB);
    chk({tag, "_tlast"}, 0, b_tlast[0], 1);
    chk({tag, "_credit"}, 0, b_credit[0], 1);
    repeat (2) tick();
    chk({tag, "_drained"}, 0, mq[0].size(), 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, run;
    logic after;
    b_send = '0;
    b_tail = '0;
    b_tready = '1;
    for (int i = 0; i < 3; i++) begin
      b_data[i] = '0;
      b_dest[i] = '0;
    end
    #1 rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_tvalid", i, b_tvalid[i], 0);
      chk("rst_credit", i, b_credit[i], 0);
      chk("rst_errs", i, {b_ovf[i], b_frag[i]}, 0);
      chk("rst_tdata", i, b_tdata[i], 0);
      chk("rst_side", i, {b_tlast[i], b_tid[i], b_tdest[i]}, 0);
    end
    tick();
    rst = 1'b0;
    tick();
    single_flit("t1");
    base = cred[2];
    drive(2, 64'h1111, 6'h1C, 1'b0, 1'b1);
    drive(2, 64'h2222, 6'h3F, 1'b0, 1'b1);
    drive(2, 64'h3333, 6'h3F, 1'b0, 1'b1);
    drive(2, 64'h4444, 6'h3F, 1'b1, 1'b1);
    wait_valid(2, 10);
    chk("t2_tdata", 2, b_tdata[2], 64'h4444_3333_2222_1111);
    chk("t2_tid", 2, b_tid[2], 2'h1);
    chk("t2_tdest", 2, b_tdest[2], 4'hC);
    chk("t2_tlast", 2, b_tlast[2], 1);
    repeat (3) tick();
    chk("t2_credits", 2, cred[2] - base, 4);
    chk("t2_errs", 2, {b_ovf[2], b_frag[2]}, {exp_ovf[2], exp_frag[2]});
    drive(1, 64'hCAFE_0001, 6'h25, 1'b1, 1'b1);
    drive(1, 64'hBEEF_0002, 6'h00, 1'b0, 1'b1);
    wait_valid(1, 10);
    chk("t4_tdata", 1, b_tdata[1], 64'hBEEF_0002_CAFE_0001);
    chk("t4_side", 1, {b_tlast[1], b_tid[1], b_tdest[1]}, {1'b0, 2'h2, 4'h5});
    chk("t4_frag", 1, b_frag[1], 1);
    chk("t4_errs_model", 1, {b_ovf[1], b_frag[1]}, {exp_ovf[1], exp_frag[1]});
    tick();
    base = cred[0];
    run = 0;
    after = 1'b1;
    fork
      for (int k = 0; k < 20; k++) drive(0, 64'hD000_0000 + 64'(k), 6'(k), 1'b1, 1'b1);
      begin
        wait_valid(0, 10);
        run = 1;
        repeat (19) begin
          @(negedge clk);
          run += int'(b_tvalid[0]);
        end
        @(negedge clk);
        after = b_tvalid[0];
      end
    join
    chk("t5_consecutive", 0, run, 20);
    chk("t5_gap_after", 0, after, 0);
    repeat (2) tick();
    chk("t5_credits", 0, cred[0] - base, 20);
    chk("t5_errs", 0, {b_ovf[0], b_frag[0]}, 0);
    chk("t5_drained", 0, mq[0].size(), 0);
    b_tready[0] = 1'b0;
    drive(0, 64'hF0, 6'h11, 1'b1, 1'b1);
    wait_valid(0, 10);
    tick();
    drive(0, 64'hF1, 6'h12, 1'b1, 1'b1);
    drive(0, 64'hF2, 6'h13, 1'b1, 1'b1);
    drive(0, 64'hF3, 6'h14, 1'b1, 1'b0);
    repeat (6) tick();
    chk("t3_overflow", 0, b_ovf[0], 1);
    chk("t3_held_valid", 0, b_tvalid[0], 1);
    chk("t3_held_tdata", 0, b_tdata[0], 64'hF0);
    base = cred[0];
    b_tready[0] = 1'b1;
    repeat (6) tick();
    chk("t3_credits", 0, cred[0] - base, 2);
    chk("t3_drained", 0, mq[0].size(), 0);
    chk("t3_errs_model", 0, {b_ovf[0], b_frag[0]}, {exp_ovf[0], exp_frag[0]});
    b_tready[0] = 1'b0;
    drive(0, 64'h77, 6'h01, 1'b1, 1'b1);
    drive(0, 64'h88, 6'h02, 1'b1, 1'b1);
    repeat (3) tick();
    chk("t6_pre_valid", 0, b_tvalid[0], 1);
    base = cred[0];
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", 0, b_tvalid[0], 0);
    chk("t6_rst_tdata", 0, b_tdata[0], 0);
    chk("t6_rst_errs", 0, {b_ovf[0], b_frag[0], b_credit[0]}, 0);
    clear_model();
    tick();
    rst = 1'b0;
    b_tready[0] = 1'b1;
    repeat (5) tick();
    chk("t6_no_credit", 0, cred[0] - base, 0);
    chk("t6_no_beat", 0, b_tvalid[0], 0);
    single_flit("t6");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
